flappy_bird_control_onchip_ram_pl: RTL and testbench
====================================================

FLAPPY_BIRD_CONTROL_ONCHIP_RAM_PL -- requirements
Module: flappy_bird_control_onchip_ram_pl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 2, word address width; DEPTH = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter READ_LATENCY, default 2, read latency in enabled cycles; legal values 1 or 2.
REQ-004 SHALL have parameter CLEAR_ON_RESET, default 1; when 1, all words are written with INIT_VALUE after reset.
REQ-005 SHALL have parameter INIT_VALUE, default 0, DATA_WIDTH-bit clear pattern.
REQ-006 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port address, input, ADDR_WIDTH, word address.
REQ-009 SHALL have port byteenable, input, DATA_WIDTH/8, write byte lanes.
REQ-010 SHALL have ports chipselect, read and write, each input, 1, Avalon-MM slave controls.
REQ-011 SHALL have port writedata, input, DATA_WIDTH, write data.
REQ-012 SHALL have port clken, input, 1, clock enable; 0 freezes the block.
REQ-013 SHALL have port reset_req, input, 1, treated as clken=0 while high.
REQ-014 SHALL have port readdata, output, DATA_WIDTH, registered read data.
REQ-015 SHALL have port readdatavalid, output, 1, one-cycle pulse per completed read.
REQ-016 SHALL have port waitrequest, output, 1, high when no transfer can be accepted.

Function
REQ-017 SHALL define en = clken & ~reset_req; when en=0, no state, counter, memory or pipeline register changes, except that readdatavalid is driven 0.
REQ-018 SHALL implement states CLEAR and READY; on reset release, CLEAR if CLEAR_ON_RESET=1, else READY.
REQ-019 In CLEAR, while en=1, SHALL write INIT_VALUE (all lanes) to word clr_cnt, starting at 0 and incrementing by 1; after writing DEPTH-1, SHALL go to READY, so the clear takes exactly DEPTH enabled cycles.
REQ-020 SHALL drive waitrequest = (state==CLEAR) | ~en.
REQ-021 SHALL accept a transfer when chipselect & (read|write) & ~waitrequest.
REQ-022 For an accepted write, SHALL update only the byte lanes whose byteenable bit is 1; byteenable=0 is accepted with no change.
REQ-023 For write=1 and read=1 together, SHALL perform the write only and produce no readdatavalid.
REQ-024 For an accepted read, SHALL present the addressed word on readdata with readdatavalid=1 exactly READ_LATENCY enabled cycles later.
REQ-025 SHALL pipeline reads, sustaining one accepted read per cycle, with responses in acceptance order.
REQ-026 A read accepted in the cycle after a write to the same address SHALL return the new data.
REQ-027 readdata SHALL hold its last value between pulses and through en=0.
REQ-028 During en=0, the read pipeline SHALL stall; the pending response SHALL be delivered on the first enabled cycle at its due position, and SHALL never be lost or duplicated.
REQ-029 All address arithmetic SHALL be modulo DEPTH, and clr_cnt SHALL not wrap past DEPTH-1.

Reset
REQ-030 While reset_n=0: readdata=0, readdatavalid=0, pipeline valids=0, clr_cnt=0, state=CLEAR (CLEAR_ON_RESET=1) or READY; waitrequest SHALL follow REQ-020.
REQ-031 Reset asserted mid-clear or mid-read SHALL abort the operation; in-flight reads produce no readdatavalid; the clear restarts from word 0.
REQ-032 Reset SHALL not directly alter the memory array; contents are defined only by the clear or by writes.

Verification (DATA_WIDTH=32, ADDR_WIDTH=2, READ_LATENCY=2, INIT_VALUE=0xA5A5A5A5, clken=1)
REQ-033 Release reset, then read words 0-3 -> waitrequest high for exactly 4 cycles after release; each read returns 0xA5A5A5A5 two cycles after acceptance.
REQ-034 Write 0x11223344 to addr 1 with be=4'b0101, then read addr 1 -> 0xA522A544.
REQ-035 Issue back-to-back reads of addr 0,1,2,3 in 4 consecutive cycles after writing distinct values -> 4 consecutive readdatavalid pulses in order, the first 2 cycles after the first read.
REQ-036 Accept a read, drop clken for 3 cycles in the next cycle -> no pulse during the stall; exactly one pulse with correct data on the second enabled cycle after acceptance; the same result with reset_req=1 instead of clken=0.
REQ-037 Assert reset_n=0 at the third clear cycle, release -> waitrequest high for 4 more cycles; all words read 0xA5A5A5A5.
REQ-038 Assert read and write together on addr 2 with 0xDEADBEEF -> no readdatavalid; a subsequent read returns 0xDEADBEEF.

Source files
------------

// File: rtl/flappy_bird_control_onchip_ram_pl.sv
// Avalon-MM on-chip RAM with byte-lane writes, pipelined reads (latency 1 or 2),
// a post-reset clear sweep, and a clock enable that freezes all state.
module flappy_bird_control_onchip_ram_pl #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 2,
  parameter int                    READ_LATENCY   = 2,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  input  logic                    clken,
  input  logic                    reset_req,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;
  localparam state_t RST_STATE = CLEAR_ON_RESET ? CLEAR : READY;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic                    p1_vld;
  logic [DATA_WIDTH-1:0]   p1_dat;
  logic                    rdv_q;
  logic                    en;
  logic                    accept;
  logic                    wr_acc;
  logic                    rd_acc;

  assign en          = clken & ~reset_req;
  assign waitrequest = (state == CLEAR) | ~en;
  assign accept      = chipselect & (read | write) & ~waitrequest;
  assign wr_acc      = accept & write;
  assign rd_acc      = accept & read & ~write;

  // The response register stays frozen while disabled, so a due pulse is only
  // hidden, then delivered on the next enabled cycle.
  assign readdatavalid = rdv_q & en;

  // The array sits outside the reset branch: reset never touches its contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RST_STATE;
      clr_cnt  <= '0;
      p1_vld   <= 1'b0;
      p1_dat   <= '0;
      rdv_q    <= 1'b0;
      readdata <= '0;
    end else if (en) begin
      if (state == CLEAR) begin
        mem[clr_cnt] <= INIT_VALUE;
        if (clr_cnt == LAST_ADDR) state <= READY;
        else clr_cnt <= clr_cnt + 1'b1;
      end else if (wr_acc) begin
        for (int i = 0; i < LANES; i++) begin
          if (byteenable[i]) mem[address][i*8 +: 8] <= writedata[i*8 +: 8];
        end
      end

      p1_vld <= rd_acc;
      if (rd_acc) p1_dat <= mem[address];

      if (READ_LATENCY == 2) begin
        rdv_q <= p1_vld;
        if (p1_vld) readdata <= p1_dat;
      end else begin
        rdv_q <= rd_acc;
        if (rd_acc) readdata <= mem[address];
      end
    end
  end

endmodule

// File: tb/tb_flappy_bird_control_onchip_ram_pl.sv
// Bench for the on-chip RAM: scenario tasks plus a cycle monitor holding a
// word-array model and an ordered queue of expected read responses.
module tb_flappy_bird_control_onchip_ram_pl;

  localparam logic [31:0] INIT = 32'hA5A5A5A5;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic [3:0]  byteenable;
  logic        chipselect, read, write;
  logic [31:0] writedata;
  logic        clken, reset_req;
  logic [31:0] readdata;
  logic        readdatavalid, waitrequest;

  flappy_bird_control_onchip_ram_pl #(
    .DATA_WIDTH(32), .ADDR_WIDTH(2), .READ_LATENCY(2),
    .CLEAR_ON_RESET(1'b1), .INIT_VALUE(INIT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .reset_req(reset_req), .readdata(readdata),
    .readdatavalid(readdatavalid), .waitrequest(waitrequest)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] dat; int due; } rsp_t;
  rsp_t        q[$];
  logic [31:0] mm [DEPTH];
  int          clr_n = 0;
  int          en_idx = 0;
  int          total = 0;
  int          bad = 0;
  bit          obs_v [16];
  logic [31:0] obs_d [16];

  // Reference model: a response is due two enabled cycles after acceptance.
  bit          m_en, m_wr;
  rsp_t        r;
  always @(negedge clk) begin
    m_en = clken & ~reset_req;
    if (!reset_n) begin
      q.delete();
      clr_n = 0;
      total++;
      if (readdatavalid !== 1'b0 || readdata !== 32'h0) begin
        bad++;
        $display("FAIL mon_reset: rdv=%b rd=%h want rdv=0 rd=0", readdatavalid, readdata);
      end
    end else begin
      if (m_en) en_idx++;
      m_wr = (clr_n < DEPTH) || !m_en;
      total++;
      if (waitrequest !== m_wr) begin
        bad++;
        $display("FAIL mon_waitreq: got %b want %b", waitrequest, m_wr);
      end
      total++;
      if (m_en && q.size() > 0 && q[0].due == en_idx) begin
        if (readdatavalid !== 1'b1 || readdata !== q[0].dat) begin
          bad++;
          $display("FAIL mon_resp: rdv=%b rd=%h want rdv=1 rd=%h", readdatavalid, readdata, q[0].dat);
        end
        void'(q.pop_front());
      end else if (readdatavalid !== 1'b0) begin
        bad++;
        $display("FAIL mon_spurious: rdv=%b want 0", readdatavalid);
      end
      if (!m_wr && chipselect && (read || write)) begin
        if (write) begin
          for (int i = 0; i < 4; i++)
            if (byteenable[i]) mm[address][i*8 +: 8] = writedata[i*8 +: 8];
        end else begin
          r.dat = mm[address];
          r.due = en_idx + 2;
          q.push_back(r);
        end
      end
      if (m_en && clr_n < DEPTH) begin
        clr_n++;
        if (clr_n == DEPTH) for (int i = 0; i < DEPTH; i++) mm[i] = INIT;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    chipselect = 1'b1; read = 1'b0; write = 1'b1;
    address = a; writedata = d; byteenable = be;
    step();
    idle();
  endtask

  // Reads nrd consecutive words from base, observing ncyc cycles from the first.
  task automatic collect(input int nrd, input int base, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      if (i < nrd) begin
        chipselect = 1'b1; read = 1'b1; write = 1'b0; address = 2'(base + i);
      end else idle();
      @(negedge clk);
      obs_v[i] = readdatavalid;
      obs_d[i] = readdata;
      step();
    end
    idle();
  endtask

  task automatic count_wait(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (waitrequest) n++;
      else break;
    end
    step();
  endtask

  task automatic test_reset();
    int n;
    reset_n = 1'b0;
    step(); step();
    @(negedge clk);
    total++;
    if (readdata !== 32'h0 || readdatavalid !== 1'b0 || waitrequest !== 1'b1) begin
      bad++;
      $display("FAIL reset_vals: rd=%h rdv=%b wr=%b want 0/0/1", readdata, readdatavalid, waitrequest);
    end
    step();
    reset_n = 1'b1;
    count_wait(n);
    total++;
    if (n != 4) begin
      bad++;
      $display("FAIL clear_len: waitrequest cycles=%0d want 4", n);
    end
    collect(4, 0, 8);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (obs_v[i] !== (i >= 2 && i <= 5) || (obs_v[i] && obs_d[i] !== INIT)) begin
        bad++;
        $display("FAIL clear_read[%0d]: rdv=%b rd=%h want rdv=%b rd=%h", i, obs_v[i], obs_d[i], (i >= 2 && i <= 5), INIT);
      end
    end
  endtask

  task automatic test_byteenable();
    do_write(2'd1, 32'h11223344, 4'b0101);
    collect(1, 1, 4);
    total++;
    if (obs_v[1] !== 1'b0 || obs_v[2] !== 1'b1 || obs_d[2] !== 32'hA522A544) begin
      bad++;
      $display("FAIL byteenable: rdv1=%b rdv2=%b rd=%h want 0/1/a522a544", obs_v[1], obs_v[2], obs_d[2]);
    end
    do_write(2'd1, 32'hFFFFFFFF, 4'b0000);
    collect(1, 1, 4);
    total++;
    if (obs_v[2] !== 1'b1 || obs_d[2] !== 32'hA522A544) begin
      bad++;
      $display("FAIL be_zero: rdv=%b rd=%h want 1/a522a544", obs_v[2], obs_d[2]);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v [4];
    for (int k = 0; k < 4; k++) begin
      v[k] = $urandom ^ (32'h01010101 * k);
      do_write(2'(k), v[k], 4'hF);
    end
    collect(4, 0, 8);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (obs_v[i] !== (i >= 2 && i <= 5) || (obs_v[i] && obs_d[i] !== v[(i - 2) & 3])) begin
        bad++;
        $display("FAIL b2b[%0d]: rdv=%b rd=%h want rdv=%b", i, obs_v[i], obs_d[i], (i >= 2 && i <= 5));
      end
    end
  endtask

  task automatic test_stall(input bit use_rr);
    logic [1:0]  a;
    logic [31:0] d;
    a = 2'($urandom);
    d = $urandom;
    do_write(a, d, 4'hF);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
    step();
    idle();
    if (use_rr) reset_req = 1'b1; else clken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (readdatavalid !== 1'b0) begin
        bad++;
        $display("FAIL stall_quiet rr=%0b c%0d: rdv=%b want 0", use_rr, i, readdatavalid);
      end
      step();
    end
    reset_req = 1'b0; clken = 1'b1;
    @(negedge clk);
    total++;
    if (readdatavalid !== 1'b0) begin
      bad++;
      $display("FAIL stall_early rr=%0b: rdv=%b want 0", use_rr, readdatavalid);
    end
    step();
    @(negedge clk);
    total++;
    if (readdatavalid !== 1'b1 || readdata !== d) begin
      bad++;
      $display("FAIL stall_resp rr=%0b: rdv=%b rd=%h want 1/%h", use_rr, readdatavalid, readdata, d);
    end
    step();
    @(negedge clk);
    total++;
    if (readdatavalid !== 1'b0 || readdata !== d) begin
      bad++;
      $display("FAIL stall_hold rr=%0b: rdv=%b rd=%h want 0/%h", use_rr, readdatavalid, readdata, d);
    end
    step();
  endtask

  task automatic test_reset_abort();
    int n;
    do_write(2'd3, 32'h0BADF00D, 4'hF);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = 2'd3;
    step();
    idle();
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step(); step();
    reset_n = 1'b0;
    step(); step();
    reset_n = 1'b1;
    count_wait(n);
    total++;
    if (n != 4) begin
      bad++;
      $display("FAIL abort_clear_len: waitrequest cycles=%0d want 4", n);
    end
    collect(4, 0, 8);
    for (int i = 2; i < 6; i++) begin
      total++;
      if (obs_v[i] !== 1'b1 || obs_d[i] !== INIT) begin
        bad++;
        $display("FAIL abort_read[%0d]: rdv=%b rd=%h want 1/%h", i - 2, obs_v[i], obs_d[i], INIT);
      end
    end
  endtask

  task automatic test_read_write_both();
    chipselect = 1'b1; read = 1'b1; write = 1'b1;
    address = 2'd2; writedata = 32'hDEADBEEF; byteenable = 4'hF;
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (readdatavalid !== 1'b0) begin
        bad++;
        $display("FAIL rw_no_pulse c%0d: rdv=%b want 0", i, readdatavalid);
      end
      step();
    end
    collect(1, 2, 4);
    total++;
    if (obs_v[2] !== 1'b1 || obs_d[2] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL rw_readback: rdv=%b rd=%h want 1/deadbeef", obs_v[2], obs_d[2]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      chipselect = ($urandom_range(0, 3) != 0);
      read       = $urandom_range(0, 1) == 1;
      write      = ($urandom_range(0, 2) == 0);
      address    = 2'($urandom);
      byteenable = 4'($urandom);
      writedata  = $urandom;
      clken      = ($urandom_range(0, 7) != 0);
      reset_req  = ($urandom_range(0, 11) == 0);
      step();
    end
    idle();
    clken = 1'b1; reset_req = 1'b0;
    repeat (5) step();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL random_drain: pending=%0d want 0", q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; address = '0; byteenable = 4'hF; writedata = '0;
    clken = 1'b1; reset_req = 1'b0;
    idle();
    step();
    test_reset();
    test_byteenable();
    test_back_to_back();
    test_stall(1'b0);
    test_stall(1'b1);
    test_reset_abort();
    test_read_write_both();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
